// File: rtl/pos_embed_pkg.sv
// Shared types, defaults and the lane saturating add for the positional-embedding stream.
// The saturating add is only used when POS_EMBED_SAT_EN is defined.
package pos_embed_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_NUM_TOKENS  = 196;
    localparam int DEF_E           = 128;
    localparam int DEF_LANES       = 4;
    localparam int BEATS_PER_FRAME = DEF_NUM_TOKENS * DEF_E / DEF_LANES;
    localparam int BEAT_AW         = $clog2(BEATS_PER_FRAME);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Operands arrive sign-extended to 32 bits; the result is clamped to a dw-bit signed range.
    function automatic logic [31:0] sat_add(input logic signed [31:0] a,
                                            input logic signed [31:0] b,
                                            input int unsigned dw);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = {a[31], a} + {b[31], b};
        hi = (33'sd1 <<< (dw - 1)) - 33'sd1;
        lo = -hi - 33'sd1;
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/pos_table_ram.sv
// Positional table storage: one write port, one registered read port, contents never reset.
// A same-cycle write to the address being read is forwarded so the new value is seen at once.
module pos_table_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 6272,
    parameter int AW    = 13
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pos_embed_stream.sv
// Streams a frame of embedding beats and adds the per-beat positional table entry to each lane.
// Build option POS_EMBED_SAT_EN: lanes saturate instead of wrapping modulo 2^DATA_WIDTH.
module pos_embed_stream
    import pos_embed_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_TOKENS = DEF_NUM_TOKENS,
    parameter int E          = DEF_E,
    parameter int LANES      = DEF_LANES
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   bypass,
    output logic                                   busy,
    output logic                                   done,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH*LANES-1:0]            in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH*LANES-1:0]            out_data,
    output logic                                   out_last,
    input  logic                                   tbl_wr_en,
    input  logic [$clog2(NUM_TOKENS*E/LANES)-1:0]  tbl_wr_addr,
    input  logic [DATA_WIDTH*LANES-1:0]            tbl_wr_data,
    output state_t                                 dbg_state
);

    localparam int BEATS = NUM_TOKENS * E / LANES;
    localparam int AW    = $clog2(BEATS);
    localparam int W     = DATA_WIDTH * LANES;
    localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);

    if (E % LANES != 0) begin : g_lane_check
        $error("E must be a multiple of LANES");
    end

`ifdef POS_EMBED_SAT_EN
    if (DATA_WIDTH > 32) begin : g_width_check
        $error("saturating lanes support DATA_WIDTH up to 32");
    end
`endif

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   beat;
    logic [AW-1:0]   beat_next;
    logic            bypass_q;
    logic            start_ok;
    logic            done_set;
    logic            in_fire;
    logic            tbl_wr_ok;
    logic [W-1:0]    tbl_rd_data;
    logic [W-1:0]    sum_data;

    // Handshakes: a beat moves on a rising edge where valid && ready; valid never waits on
    // ready, and the output register holds its beat until out_ready accepts it.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        start_ok   = 1'b0;
        done_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    start_ok   = 1'b1;
                end
            end
            S_RUN: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready && (beat == LAST_BEAT)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    state_next = S_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;
    assign in_fire   = in_valid && in_ready;
    assign tbl_wr_ok = tbl_wr_en && (state == S_IDLE);

    // The table is fetched with the index of the beat that will be presented next cycle.
    always_comb begin
        beat_next = beat;
        if (in_fire) begin
            beat_next = (beat == LAST_BEAT) ? '0 : beat + AW'(1);
        end
    end

    pos_table_ram #(
        .WIDTH (W),
        .DEPTH (BEATS),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .wr_en   (tbl_wr_ok),
        .wr_addr (tbl_wr_addr),
        .wr_data (tbl_wr_data),
        .rd_addr (beat_next),
        .rd_data (tbl_rd_data)
    );

    always_comb begin
        sum_data = '0;
        for (int l = 0; l < LANES; l++) begin
`ifdef POS_EMBED_SAT_EN
            sum_data[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sat_add(
                32'(signed'(in_data[l*DATA_WIDTH +: DATA_WIDTH])),
                32'(signed'(tbl_rd_data[l*DATA_WIDTH +: DATA_WIDTH])),
                DATA_WIDTH));
`else
            // Two's-complement add truncated to the lane width wraps modulo 2^DATA_WIDTH.
            sum_data[l*DATA_WIDTH +: DATA_WIDTH] = in_data[l*DATA_WIDTH +: DATA_WIDTH]
                                                 + tbl_rd_data[l*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= '0;
            bypass_q  <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            beat <= beat_next;
            done <= done_set;
            if (start_ok) begin
                bypass_q <= bypass;
            end
            if (in_fire) begin
                out_valid <= 1'b1;
                out_data  <= bypass_q ? in_data : sum_data;
                out_last  <= (beat == LAST_BEAT);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pos_embed_stream.sv
// Randomized self-checking bench for pos_embed_stream with a lane-arithmetic reference model
// and an expected-beat queue; mirrors the POS_EMBED_SAT_EN build option in its model.
module tb_pos_embed_stream;
    import pos_embed_pkg::*;

    localparam int DW    = 16;
    localparam int NT    = 196;
    localparam int EMB   = 128;
    localparam int LN    = 4;
    localparam int BEATS = NT * EMB / LN;
    localparam int AW    = $clog2(BEATS);
    localparam int W     = DW * LN;
    localparam int LIMIT = 40000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          bypass = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          tbl_wr_en = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  tbl_wr_data = '0;
    logic [AW-1:0] tbl_wr_addr = '0;
    logic          busy, done, in_ready, out_valid, out_last;
    logic [W-1:0]  out_data;
    state_t        dbg_state;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  tbl_model [BEATS];
    logic          ws_en = 1'b0;
    logic [W-1:0]  ws_data = '0;

    pos_embed_stream dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bypass      (bypass),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_wr_data (tbl_wr_data),
        .dbg_state   (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: signed lane add, clamped or wrapped to DW bits
    function automatic logic [W-1:0] model_beat(input logic [W-1:0] din, input logic [W-1:0] t,
                                                input bit byp);
        logic [W-1:0] r;
        int a, b, s;
        r = '0;
        if (byp) return din;
        for (int l = 0; l < LN; l++) begin
            a = int'($signed(din[l*DW +: DW]));
            b = int'($signed(t[l*DW +: DW]));
            s = a + b;
`ifdef POS_EMBED_SAT_EN
            if (s > (1 << (DW - 1)) - 1) s = (1 << (DW - 1)) - 1;
            else if (s < -(1 << (DW - 1))) s = -(1 << (DW - 1));
`endif
            r[l*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; start = 1'b0; tbl_wr_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, out_last, done, busy, in_ready} !== 5'b0) begin
                errors++;
                $display("FAIL %s reset_ctrl: got %b expected 00000", tag,
                         {out_valid, out_last, done, busy, in_ready});
            end
            checks++;
            if (out_data !== '0) begin
                errors++;
                $display("FAIL %s reset_data: got %h expected 0", tag, out_data);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic load_table();
        logic [15:0] k16;
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            k16 = k[15:0];
            tbl_wr_en = 1'b1; tbl_wr_addr = AW'(k); tbl_wr_data = {LN{k16}};
            tbl_model[k] = {LN{k16}};
        end
        @(negedge clk);
        tbl_wr_en = 1'b0;
    endtask

    // Drives one frame (or its first abort_at beats) and scoreboards every output beat
    task automatic run_frame(input bit byp, input int in_mode, input int in_pct, input int out_pct,
                             input int abort_at, input int wr_at, input bit chk_timing,
                             input string tag);
        int in_idx, out_idx, budget, first_cyc;
        bit in_fire, out_fire, stalled, exp_rdy;
        logic [W-1:0] held, exp_v;
        in_idx = 0; out_idx = 0; budget = 0; first_cyc = -1; stalled = 1'b0; held = '0;
        @(negedge clk);
        start = 1'b1; bypass = byp;
        tbl_wr_en = ws_en; tbl_wr_addr = '0; tbl_wr_data = ws_data;
        if (ws_en) tbl_model[0] = ws_data;
        @(negedge clk);
        start = 1'b0; bypass = ~byp; tbl_wr_en = 1'b0; ws_en = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b expected 1", tag, busy);
        end
        while (out_idx < BEATS && in_idx < abort_at && budget < LIMIT) begin
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_q.size() != 0);
            end
            if (stalled) begin
                checks++;
                if (out_data !== held) begin
                    errors++;
                    $display("FAIL %s stall_hold: got %h expected %h", tag, out_data, held);
                end
            end
            in_valid  = (in_idx < BEATS) && ($urandom_range(99) < in_pct);
            in_data   = (in_mode == 0) ? {LN{16'h0001}} : {$urandom(), $urandom()};
            out_ready = ($urandom_range(99) < out_pct);
            start     = (in_idx == 50);
            tbl_wr_en = (in_idx == wr_at);
            if (wr_at >= 0) begin
                tbl_wr_addr = AW'(wr_at);
                tbl_wr_data = ~tbl_model[wr_at];
            end
            #1;
            exp_rdy = (in_idx < BEATS) && (!out_valid || out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL %s in_ready: got %b expected %b", tag, in_ready, exp_rdy);
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_beat: got beat %0d expected none", tag, out_idx);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) begin
                        errors++;
                        $display("FAIL %s beat_%0d data: got %h expected %h", tag, out_idx, out_data, exp_v);
                    end
                    checks++;
                    if (out_last !== (out_idx == BEATS - 1)) begin
                        errors++;
                        $display("FAIL %s beat_%0d last: got %b expected %b", tag, out_idx, out_last,
                                 out_idx == BEATS - 1);
                    end
                end
                out_idx++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_fire) begin
                exp_q.push_back(model_beat(in_data, tbl_model[in_idx], byp));
                if (first_cyc < 0) first_cyc = cyc;
                in_idx++;
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0; start = 1'b0; tbl_wr_en = 1'b0;
        if (budget >= LIMIT) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d beats expected %0d", tag, out_idx, BEATS);
        end else if (out_idx == BEATS) begin
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL %s done: got %b expected 1", tag, done);
            end
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_after_frame: got busy=%b out_valid=%b expected 0 0", tag, busy, out_valid);
            end
            if (chk_timing) begin
                checks++;
                if (cyc - first_cyc !== BEATS + 1) begin
                    errors++;
                    $display("FAIL %s done_latency: got %0d expected %0d", tag, cyc - first_cyc, BEATS + 1);
                end
            end
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_in_idle: got %b expected 0", tag, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse: got done=%b out_valid=%b expected 0 0", tag, done, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        do_reset("power_on");
        checks++;
        if (dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL power_on state: got %0d expected %0d", dbg_state, S_IDLE);
        end
    endtask

    task automatic test_full_frame();
        run_frame(1'b0, 0, 100, 100, BEATS + 1, -1, 1'b1, "full_frame");
    endtask

    task automatic test_reset_mid_frame();
        run_frame(1'b0, 0, 100, 100, 100, -1, 1'b0, "pre_reset");
        do_reset("mid_frame");
        checks++;
        if (dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL mid_frame state: got %0d expected %0d", dbg_state, S_IDLE);
        end
    endtask

    task automatic test_backpressure();
        run_frame(1'b0, 0, 100, 50, BEATS + 1, -1, 1'b0, "backpressure");
    endtask

    task automatic test_bypass();
        run_frame(1'b1, 1, 100, 100, BEATS + 1, -1, 1'b0, "bypass");
    endtask

    task automatic test_write_busy();
        run_frame(1'b0, 0, 100, 100, 40, 5, 1'b0, "write_busy");
        do_reset("write_busy");
    endtask

    task automatic test_write_with_start();
        ws_en   = 1'b1;
        ws_data = {$urandom(), $urandom()};
        run_frame(1'b0, 0, 100, 100, 10, -1, 1'b0, "write_with_start");
        do_reset("write_with_start");
    endtask

    task automatic test_random_data();
        run_frame(1'b0, 1, 70, 80, 600, -1, 1'b0, "random_data");
        do_reset("random_data");
    endtask

    task automatic test_saturation();
        logic [W-1:0] pat_in, pat_tbl, want;
        pat_in  = {16'h8000, 16'h7FF0, 16'h8000, 16'h7FF0};
        pat_tbl = {16'hFFFF, 16'h0020, 16'hFFFF, 16'h0020};
`ifdef POS_EMBED_SAT_EN
        want = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
`else
        want = {16'h7FFF, 16'h8010, 16'h7FFF, 16'h8010};
`endif
        @(negedge clk);
        tbl_wr_en = 1'b1; tbl_wr_addr = '0; tbl_wr_data = pat_tbl; tbl_model[0] = pat_tbl;
        @(negedge clk);
        tbl_wr_en = 1'b0; start = 1'b1; bypass = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = pat_in;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL saturation ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== want) begin
            errors++;
            $display("FAIL saturation data: got v=%b %h expected v=1 %h", out_valid, out_data, want);
        end
        do_reset("saturation");
    endtask

    initial begin
        test_reset();
        load_table();
        test_full_frame();
        test_reset_mid_frame();
        test_backpressure();
        test_bypass();
        test_write_busy();
        test_write_with_start();
        test_random_data();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pos_embed_stream.md
POS_EMBED_STREAM -- requirements
Module: pos_embed_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed two's-complement element width.
REQ-002 Parameter NUM_TOKENS, default 196, tokens per frame.
REQ-003 Parameter E, default 128, embedding dimension; E % LANES == 0 is required and is checked at elaboration.
REQ-004 Parameter LANES, default 4, elements processed per beat.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle pulse that begins a frame.
REQ-008 bypass  input  1  sampled at start; 1 means out = in with no table add.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse at end of frame.
REQ-011 in_valid / in_ready  input / output  1 / 1  input beat handshake.
REQ-012 in_data  input  DATA_WIDTH*LANES  LANES elements; lane 0 in the LSBs.
REQ-013 out_valid / out_ready  output / input  1 / 1  output beat handshake.
REQ-014 out_data  output  DATA_WIDTH*LANES  sum beat; out_last  output  1  marks the final beat of a frame.
REQ-015 tbl_wr_en, tbl_wr_addr[clog2(NUM_TOKENS*E/LANES)-1:0], tbl_wr_data[DATA_WIDTH*LANES-1:0]  inputs  positional table write port, one beat per write.

Function
REQ-016 FSM states: S_IDLE, S_RUN, S_DRAIN.
- S_IDLE to S_RUN on start.
- S_RUN to S_DRAIN when the last input beat is accepted.
- S_DRAIN to S_IDLE when the last output beat is accepted; done pulses on that same edge.
REQ-017 A beat transfers on valid&&ready.
- Beat order: token-major, dimension-minor.
- A frame is NUM_TOKENS*E/LANES beats.
- The beat counter advances only on an input transfer.
REQ-018 in_ready = (state==S_RUN) && (!out_valid || out_ready). This is a single output register stage with no combinational path from in_valid to out_valid.
REQ-019 Latency: an accepted input beat appears on out_data on the next cycle. out_data holds stable while out_valid && !out_ready.
REQ-020 Per lane, out = in + table[beat][lane] using DATA_WIDTH+1-bit signed intermediate arithmetic. Overflow handling is per REQ-029/REQ-030.
REQ-021 out_last = 1 only on beat index NUM_TOKENS*E/LANES-1.
REQ-022 start while busy is ignored. in_valid outside S_RUN is ignored (in_ready=0).
REQ-023 Table writes are honoured only in S_IDLE and are ignored while busy. A write and a start in the same cycle: the write completes and the frame uses the new value.
REQ-024 The table is read synchronously, addressed by the next beat index, so the table value is aligned with the input beat. Back-pressure does not skip or repeat entries.
REQ-025 The bypass mode is latched for the whole frame.

Reset
REQ-026 On rst_n low, from any state including mid-frame:
- state returns to S_IDLE
- beat counter = 0
- out_valid, out_last, done, busy, in_ready = 0
- out_data = 0
REQ-027 Table contents are not reset. They remain valid across a reset applied mid-frame.
REQ-028 After reset deassertion, the first start begins a fresh frame at beat 0.

Configuration
REQ-029 With POS_EMBED_SAT_EN defined, each lane saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-030 Without POS_EMBED_SAT_EN, each lane wraps modulo 2^DATA_WIDTH. No saturation logic is present.

Structure
REQ-031 Package pos_embed_pkg holds:
- the state_t enum
- the saturating-add function
- localparams BEATS_PER_FRAME and BEAT_AW
REQ-032 Sub-module pos_table_ram holds the BEATS_PER_FRAME x (DATA_WIDTH*LANES) storage: one write port, one synchronous read port, no reset.

Verification
REQ-033 Defaults, table[k] = k per lane, in_data all 1, out_ready=1.
- Beat k outputs k+1 per lane.
- 6272 beats, then out_last then done, 6273 cycles after the first accept.
REQ-034 Toggle out_ready with a random 50% pattern.
- Output sequence is identical to REQ-033 with no lost or duplicated beats.
- out_data is stable while stalled.
REQ-035 With POS_EMBED_SAT_EN: in=0x7FF0, table=0x0020 gives out=0x7FFF; in=0x8000, table=0xFFFF gives out=0x8000.
- Without the macro, the same stimulus gives 0x8010 and 0x7FFF.
REQ-036 bypass=1 at start with a non-zero table: out_data equals in_data on every beat.
REQ-037 Assert rst_n low at beat 100 of a frame.
- All outputs are 0 within the reset window.
- A new start replays from beat 0 with the correct table values.
REQ-038 Issue tbl_wr_en at beat 5 while busy.
- Entry 5 is unchanged in the frame.
- Writing in S_IDLE with simultaneous start uses the new value.
